ysyx_23060221_ifu: RTL and testbench

Instruction fetch unit for the NPC core, at the receiving end of the writeback-to-fetch handshake. It accepts the next PC when the writeback unit presents it (`WBU_valid`/`IFU_ready`), then fetches one 32-bit instruction over an AXI4-Lite read channel. It presents the instruction to decode with an `IFU_valid`/`IDU_ready` handshake. Only one instruction is outstanding at any time.

---
 rtl/ysyx_23060221_ifu_pkg.sv | 15 +
 rtl/ysyx_23060221_ifu.sv | 103 ++++++++++
 tb/tb_ysyx_23060221_ifu.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060221_ifu_pkg.sv
// Shared definitions for instruction fetch: FSM state encodings, AXI response
// code and the architectural reset PC.
package ysyx_23060221_ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RRESP_OKAY = 2'b00;
    localparam logic [31:0] RESET_PC   = 32'h30000000;

endpackage

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: takes a PC from writeback, fetches one word over AXI4-Lite
// read, hands it to decode. Optional fault reporting under `IFU_FAULT_CHECK_EN`.
module ysyx_23060221_ifu
    import ysyx_23060221_ifu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            WBU_valid,
    output logic            IFU_ready,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            ifu_err,
    output logic            IFU_valid,
    input  logic            IDU_ready
);

    ifu_state_e      state, state_n;
    logic            out_armed;
    logic            pc_misaligned;
    logic [XLEN-1:0] fetch_addr;

`ifdef IFU_FAULT_CHECK_EN
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign fetch_addr    = pc;
`else
    logic unused_rresp;
    assign unused_rresp  = ^rresp;
    assign pc_misaligned = 1'b0;
    assign fetch_addr    = {pc[XLEN-1:2], 2'b00};
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (WBU_valid) state_n = pc_misaligned ? OUT : REQ;
            REQ:     if (arready)   state_n = RESP;
            RESP:    if (rvalid)    state_n = OUT;
            // decode may only take the instruction from the second OUT cycle on
            OUT:     if (IDU_ready && out_armed) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state, so no input
    // reaches an output combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            IFU_ready <= 1'b1;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            IFU_valid <= 1'b0;
            out_armed <= 1'b0;
        end else begin
            state     <= state_n;
            IFU_ready <= (state_n == IDLE);
            arvalid   <= (state_n == REQ);
            rready    <= (state_n == RESP);
            IFU_valid <= (state_n == OUT);
            out_armed <= (state == OUT) && (state_n == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr  <= '0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            if (state == IDLE && WBU_valid) begin
                araddr  <= fetch_addr;
                inst_pc <= pc;
                if (pc_misaligned) inst <= '0;
            end
            if (state == RESP && rvalid) inst <= rdata;
        end
    end

`ifdef IFU_FAULT_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_err <= 1'b0;
        end else if (state == IDLE && WBU_valid && pc_misaligned) begin
            ifu_err <= 1'b1;
        end else if (state == RESP && rvalid) begin
            ifu_err <= (rresp != RRESP_OKAY);
        end
    end
`else
    assign ifu_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// Self-checking bench for ysyx_23060221_ifu: transaction-level model compared
// every cycle, plus directed literal checks on the reference timeline.
module tb_ysyx_23060221_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        WBU_valid = 1'b0;
    logic        IFU_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        ifu_err;
    logic        IFU_valid;
    logic        IDU_ready = 1'b0;

    ysyx_23060221_ifu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .WBU_valid(WBU_valid), .IFU_ready(IFU_ready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rvalid(rvalid), .rready(rready), .inst(inst),
        .inst_pc(inst_pc), .ifu_err(ifu_err), .IFU_valid(IFU_valid), .IDU_ready(IDU_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    endtask

    // Model: one fetch transaction in flight, tracked by what it still waits for.
    logic        m_busy, m_addr, m_data, m_have, m_err;
    int          m_age;
    logic [31:0] m_araddr, m_pc, m_inst;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_addr <= 0; m_data <= 0; m_have <= 0; m_err <= 0;
            m_age <= 0; m_araddr <= '0; m_pc <= '0; m_inst <= '0;
        end else if (!m_busy) begin
            if (WBU_valid) begin
                m_busy <= 1;
                m_pc   <= pc;
`ifdef IFU_FAULT_CHECK_EN
                m_araddr <= pc;
                if (pc[1:0] != 2'b00) begin
                    m_have <= 1; m_age <= 0; m_inst <= '0; m_err <= 1;
                end else m_addr <= 1;
`else
                m_araddr <= {pc[31:2], 2'b00};
                m_addr   <= 1;
`endif
            end
        end else if (m_addr) begin
            if (arready) begin m_addr <= 0; m_data <= 1; end
        end else if (m_data) begin
            if (rvalid) begin
                m_data <= 0; m_have <= 1; m_age <= 0; m_inst <= rdata;
`ifdef IFU_FAULT_CHECK_EN
                m_err <= (rresp != 2'b00);
`endif
            end
        end else if (m_have) begin
            if (IDU_ready && m_age >= 1) begin m_have <= 0; m_busy <= 0; end
            else m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("cmp_IFU_ready", {31'b0, IFU_ready}, {31'b0, !m_busy});
            chk("cmp_arvalid",   {31'b0, arvalid},   {31'b0, m_addr});
            chk("cmp_rready",    {31'b0, rready},    {31'b0, m_data});
            chk("cmp_IFU_valid", {31'b0, IFU_valid}, {31'b0, m_have});
            if (m_addr) chk("cmp_araddr", araddr, m_araddr);
            if (m_have) begin
                chk("cmp_inst",    inst,    m_inst);
                chk("cmp_inst_pc", inst_pc, m_pc);
                chk("cmp_ifu_err", {31'b0, ifu_err}, {31'b0, m_err});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_IFU_ready", {31'b0, IFU_ready}, 32'd1);
        chk("rst_arvalid",   {31'b0, arvalid},   32'd0);
        chk("rst_rready",    {31'b0, rready},    32'd0);
        chk("rst_IFU_valid", {31'b0, IFU_valid}, 32'd0);
        chk("rst_ifu_err",   {31'b0, ifu_err},   32'd0);
        chk("rst_araddr",    araddr,  32'h0);
        chk("rst_inst",      inst,    32'h0);
        chk("rst_inst_pc",   inst_pc, 32'h0);
        rst = 1'b1;
        step();

        // basic fetch, everything ready
        pc = 32'h30000000; WBU_valid = 1; arready = 1; rvalid = 1; rdata = 32'h00000413;
        step();
        WBU_valid = 0;
        chk("t1_arvalid", {31'b0, arvalid}, 32'd1);
        chk("t1_araddr",  araddr, 32'h30000000);
        step();
        chk("t1_rready", {31'b0, rready}, 32'd1);
        step();
        chk("t1_IFU_valid", {31'b0, IFU_valid}, 32'd1);
        chk("t1_inst", inst, 32'h00000413);
        IDU_ready = 1;
        step();
        chk("t1_valid_rise_no_hs", {31'b0, IFU_valid}, 32'd1);
        step();
        chk("t1_IFU_ready_back", {31'b0, IFU_ready}, 32'd1);
        chk("t1_IFU_valid_clr",  {31'b0, IFU_valid}, 32'd0);
        IDU_ready = 0;

        // arready delayed four cycles
        pc = 32'h30000010; WBU_valid = 1; arready = 0; rvalid = 0;
        step();
        WBU_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_arvalid_hold", {31'b0, arvalid}, 32'd1);
            chk("t2_araddr_hold",  araddr, 32'h30000010);
            chk("t2_rready_low",   {31'b0, rready}, 32'd0);
            if (i == 3) arready = 1;
            step();
        end
        chk("t2_rready", {31'b0, rready}, 32'd1);
        chk("t2_arvalid_drop", {31'b0, arvalid}, 32'd0);
        arready = 0; rvalid = 1; rdata = 32'hdeadbeef;
        step();
        rvalid = 0;
        chk("t2_IFU_valid", {31'b0, IFU_valid}, 32'd1);
        chk("t2_inst", inst, 32'hdeadbeef);
        chk("t2_inst_pc", inst_pc, 32'h30000010);

        // decode stalls with writeback pushing
        pc = 32'h30000020; WBU_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_inst_held", inst, 32'hdeadbeef);
            chk("t3_IFU_ready_low", {31'b0, IFU_ready}, 32'd0);
            chk("t3_no_arvalid", {31'b0, arvalid}, 32'd0);
        end
        IDU_ready = 1; arready = 1; rvalid = 1; rdata = 32'h00100093;
        step();
        IDU_ready = 0;
        chk("t3_IFU_ready", {31'b0, IFU_ready}, 32'd1);
        step();
        WBU_valid = 0;
        chk("t3_araddr", araddr, 32'h30000020);
        step(); step();
        chk("t3_inst", inst, 32'h00100093);
        chk("t3_inst_pc", inst_pc, 32'h30000020);
        IDU_ready = 1;
        step(); step();
        IDU_ready = 0;

        // reset asserted while waiting for read data
        pc = 32'h30000100; WBU_valid = 1; arready = 1; rvalid = 0;
        step();
        WBU_valid = 0;
        step();
        chk("t4_in_resp", {31'b0, rready}, 32'd1);
        #2 rst = 0;
        #1;
        chk("t4_async_rready",    {31'b0, rready},    32'd0);
        chk("t4_async_IFU_ready", {31'b0, IFU_ready}, 32'd1);
        chk("t4_async_inst_pc",   inst_pc, 32'h0);
        step();
        rst = 1;
        pc = 32'h30000200; WBU_valid = 1; arready = 1; rvalid = 1; rdata = 32'h00200113;
        step();
        WBU_valid = 0;
        step(); step();
        chk("t4_after_rst_inst", inst, 32'h00200113);
        IDU_ready = 1;
        step(); step();
        IDU_ready = 0;

        // misaligned PC
        pc = 32'h30000002; WBU_valid = 1; arready = 1; rvalid = 1; rdata = 32'h00300193;
        step();
        WBU_valid = 0;
`ifdef IFU_FAULT_CHECK_EN
        chk("t5_fault_valid", {31'b0, IFU_valid}, 32'd1);
        chk("t5_fault_err",   {31'b0, ifu_err},   32'd1);
        chk("t5_fault_inst",  inst, 32'h0);
        chk("t5_fault_noar",  {31'b0, arvalid},   32'd0);
        IDU_ready = 1;
        step(); step();
        IDU_ready = 0;
        pc = 32'h30000004; WBU_valid = 1; rresp = 2'b10;
        step();
        WBU_valid = 0;
        step(); step();
        chk("t6_rresp_err", {31'b0, ifu_err}, 32'd1);
        rresp = 2'b00;
`else
        chk("t5_araddr_aligned", araddr, 32'h30000000);
        step(); step();
        chk("t5_ifu_err_zero", {31'b0, ifu_err}, 32'd0);
        chk("t5_inst_pc", inst_pc, 32'h30000002);
`endif
        IDU_ready = 1;
        step(); step();
        IDU_ready = 0;

        // everything held high: back-to-back fetches at full rate
        WBU_valid = 1; arready = 1; rvalid = 1; IDU_ready = 1;
        for (int i = 0; i < 16; i++) begin
            pc    = 32'h30001000 + 32'(i * 4);
            rdata = 32'h00000013 + 32'(i << 7);
            step();
        end
        WBU_valid = 0; arready = 0; rvalid = 0;
        step(); step(); step(); step();
        IDU_ready = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
